// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with per-digit on-time and blank guard.
// Optional leading-zero suppression is compiled in when SEG_LZ_SUPPRESS_EN is defined.
module seg_scan_ctrl #(
  parameter int DRIVE_CYC = 100000,
  parameter int GUARD_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_blank,
  input  logic       wr_dp,
  output logic [3:0] AN,
  output logic [6:0] seg,
  output logic       DP,
  output logic       frame_done
);

  localparam int MAX_CYC = (DRIVE_CYC > GUARD_CYC) ? DRIVE_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  logic [1:0]       state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fd_n;

  logic [3:0] dig_val [4];
  logic [3:0] dig_blank;
  logic [3:0] dig_dp;

  logic [3:0] lz;
  logic [3:0] an_sel;
  logic [3:0] cur_val;
  logic       cur_blank;
  logic       cur_dp;
  logic       cur_lz;

  // Active-low {a,b,c,d,e,f,g} glyphs for 0123456789AbCdEF.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt + 1'b1;
    fd_n    = 1'b0;
    if (!en) begin
      state_n = S_OFF;
      ptr_n   = 2'd3;
      cnt_n   = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = S_DRIVE;
          ptr_n   = 2'd3;
          cnt_n   = '0;
        end
        S_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            cnt_n = '0;
            if (GUARD_CYC == 0) begin
              ptr_n = ptr - 2'd1;
              fd_n  = (ptr == 2'd0);
            end else begin
              state_n = S_GUARD;
            end
          end
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            cnt_n   = '0;
            state_n = S_DRIVE;
            ptr_n   = ptr - 2'd1;
            fd_n    = (ptr == 2'd0);
          end
        end
        default: begin
          state_n = S_OFF;
          ptr_n   = 2'd3;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
      ptr   <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dig_val[i] <= 4'h0;
      dig_blank <= 4'hF;
      dig_dp    <= 4'h0;
    end else if (wr_en) begin
      dig_val[wr_addr]   <= wr_data;
      dig_blank[wr_addr] <= wr_blank;
      dig_dp[wr_addr]    <= wr_dp;
    end
  end

`ifdef SEG_LZ_SUPPRESS_EN
  // A digit counts as "leading" only if everything to its left is zero or dark.
  logic [3:0] dig_zero;
  logic [3:0] dig_lead;
  always_comb begin
    for (int i = 0; i < 4; i++) dig_zero[i] = (dig_val[i] == 4'h0);
    dig_lead = dig_zero | dig_blank;
    lz[3] = dig_zero[3];
    lz[2] = dig_zero[2] & dig_lead[3];
    lz[1] = dig_zero[1] & dig_lead[3] & dig_lead[2];
    lz[0] = 1'b0;
  end
`else
  assign lz = 4'b0000;
`endif

  always_comb begin
    an_sel      = 4'b1111;
    an_sel[ptr] = 1'b0;
    cur_val     = dig_val[ptr];
    cur_blank   = dig_blank[ptr];
    cur_dp      = dig_dp[ptr];
    cur_lz      = lz[ptr];
  end

  // Output stage: registered view of the current phase, one cycle behind the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN         <= 4'b1111;
      seg        <= 7'b1111111;
      DP         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fd_n;
      if (state == S_DRIVE) begin
        AN  <= an_sel;
        seg <= (cur_blank | cur_lz) ? 7'b1111111 : seg7(cur_val);
        DP  <= cur_blank ? 1'b1 : ~cur_dp;
      end else begin
        AN  <= 4'b1111;
        seg <= 7'b1111111;
        DP  <= 1'b1;
      end
    end
  end

endmodule
